// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Operands are captured at grant; the result is registered and returned over a valid/ready channel.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int NOPS  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_flags
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [4:0] NOPS_L = 5'(NOPS);

    state_t           state;
    logic             owner;
    logic             last_grant;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [3:0]       op_p0;

    logic             gnt_any;
    logic             gnt_id;
    logic             op_bad;
    logic             rsp_hs;

    function automatic logic op_is_illegal(input logic [3:0] op);
        return {1'b0, op} >= NOPS_L;
    endfunction

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE && !reset) begin
            gnt_any = req0_valid | req1_valid;
            if (req0_valid && req1_valid)
                gnt_id = ~last_grant;
            else
                gnt_id = req1_valid;
        end
    end

    assign req0_ready = gnt_any & ~gnt_id;
    assign req1_ready = gnt_any &  gnt_id;

    assign rsp0_valid = (state == RESP) & ~owner;
    assign rsp1_valid = (state == RESP) &  owner;
    assign rsp_hs     = owner ? rsp1_ready : rsp0_ready;

    assign alu_a    = a_p0;
    assign alu_b    = b_p0;
    assign alu_ctrl = op_p0;
    assign op_bad   = op_is_illegal(op_p0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_p0       <= '0;
            b_p0       <= '0;
            op_p0      <= '0;
            rsp_data   <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                // Grant: capture operands of the winner.
                IDLE: begin
                    if (gnt_any) begin
                        a_p0       <= gnt_id ? req1_a  : req0_a;
                        b_p0       <= gnt_id ? req1_b  : req0_b;
                        op_p0      <= gnt_id ? req1_op : req0_op;
                        owner      <= gnt_id;
                        last_grant <= gnt_id;
                        state      <= EXEC;
                    end
                end
                // Execute: register ALU result, squashed for illegal codes.
                EXEC: begin
                    rsp_err   <= op_bad;
                    rsp_data  <= op_bad ? '0 : alu_out;
                    rsp_flags <= op_bad ? '0 : alu_flags;
                    state     <= RESP;
                end
                // Respond: hold until the owner takes the result.
                RESP: begin
                    if (rsp_hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached to the ALU ports.
// Directed vectors push hand-computed responses; a negedge monitor pops them on each response handshake.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_ctrl, alu_flags;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [3:0]  flags;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic gseq[$];

    alu_arbiter #(.WIDTH(32), .NOPS(10)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_flags(alu_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 0 add, 1 sub (carry = borrow), anything else xor with carry/overflow forced high.
    always_comb begin
        logic        c;
        logic        v;
        logic [32:0] t;
        t = '0;
        c = 1'b0;
        v = 1'b0;
        case (alu_ctrl)
            4'd0: begin
                t = {1'b0, alu_a} + {1'b0, alu_b};
                c = t[32];
                v = (alu_a[31] == alu_b[31]) && (t[31] != alu_a[31]);
            end
            4'd1: begin
                t = {1'b0, alu_a} - {1'b0, alu_b};
                c = alu_a < alu_b;
                v = (alu_a[31] != alu_b[31]) && (t[31] != alu_a[31]);
            end
            default: begin
                t = {1'b0, alu_a ^ alu_b};
                c = 1'b1;
                v = 1'b1;
            end
        endcase
        alu_out   = t[31:0];
        alu_flags = {(t[31:0] == 32'd0), t[31], c, v};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (rsp0_valid && rsp1_valid)
                fail_now("both_rsp_valid");
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_response");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_port",  {31'd0, rsp1_valid}, {31'd0, e.port});
                    chk("rsp_data",  rsp_data, e.data);
                    chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
                    chk("rsp_err",   {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic port, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] ed, input logic [3:0] ef,
                         input logic ee, input bit push);
        bit got;
        got = 0;
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                got = 1;
                if (push) sb.push_back('{port, ed, ef, ee});
            end
        end
        if (!got) fail_now(port ? "grant_timeout_1" : "grant_timeout_0");
        step();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_op = 4'd0;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_op = 4'd1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_flags", {28'd0, rsp_flags}, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        step();
        reset = 1'b0;

        // Fair arbitration with both requesters held valid.
        for (int i = 0; i < 60 && gseq.size() < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin gseq.push_back(1'b0); sb.push_back('{1'b0, 32'd13, 4'b0000, 1'b0}); end
            if (req1_ready) begin gseq.push_back(1'b1); sb.push_back('{1'b1, 32'd7, 4'b0000, 1'b0}); end
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("fair_grant_count", gseq.size(), 32'd4);
        for (int i = 0; i < 4 && i < gseq.size(); i++)
            chk($sformatf("fair_grant_%0d", i), {31'd0, gseq[i]}, {31'd0, 1'(i % 2)});
        drain();

        // Single request and latency.
        issue(1'b0, 32'd5, 32'd7, 4'd0, 32'd12, 4'b0000, 1'b0, 1);
        @(negedge clk);
        chk("lat_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("lat_alu_a", alu_a, 32'd5);
        @(negedge clk);
        chk("lat_t2_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        drain();

        // Flag passthrough.
        issue(1'b0, 32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 4'b0001, 1'b0, 1);
        drain();
        issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 4'b1010, 1'b0, 1);
        drain();

        // Backpressure on response port 1 while requester 0 waits.
        rsp1_ready = 1'b0;
        issue(1'b1, 32'd100, 32'd23, 4'd0, 32'd123, 4'b0000, 1'b0, 1);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 4'd0;
        @(negedge clk);
        chk("bp_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'd123);
            chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
        end
        step();
        rsp1_ready = 1'b1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        chk("bp_hs_req0_ready", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        chk("bp_after_req0_ready", {31'd0, req0_ready}, 32'd1);
        chk("bp_after_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        if (req0_ready) sb.push_back('{1'b0, 32'd3, 4'b0000, 1'b0});
        step();
        req0_valid = 1'b0;
        rsp0_ready = 1'b1;
        drain();

        // Illegal op: result and flags squashed although the ALU output is non-zero.
        issue(1'b0, 32'd5, 32'd7, 4'b1100, 32'd0, 4'b0000, 1'b1, 1);
        drain();

        // Reset during EXEC discards the operation.
        issue(1'b1, 32'd40, 32'd2, 4'd0, 32'd0, 4'b0000, 1'b0, 0);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("rst_mid_alu_a", alu_a, 32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp1", {31'd0, rsp1_valid}, 32'd0);
        end
        step();
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_op = 4'd0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'd1;
        @(negedge clk);
        chk("post_rst_req0_first", {31'd0, req0_ready}, 32'd1);
        chk("post_rst_req1_wait", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) sb.push_back('{1'b0, 32'd4, 4'b0000, 1'b0});
        step();
        req0_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) begin
                got = 1;
                sb.push_back('{1'b1, 32'd5, 4'b0000, 1'b0});
            end
        end
        if (!got) fail_now("post_rst_req1_grant_timeout");
        step();
        req1_valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single ALU between two requesters, port 0 (execute stage) and port 1 (address/branch helper), using round-robin arbitration. Accepted operands are held in registers that drive the ALU ports. The ALU result and flags are registered and returned to the owning requester over a valid/ready response channel. The block sits between the requesters and the combinational ALU; the ALU is instantiated outside this block.

Parameters:
WIDTH, 32, operand/result width; must match the ALU width
NOPS, 10, number of legal ALU control codes (0..NOPS-1); higher codes are illegal

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a, req0_b  in  WIDTH  requester 0 operands
req0_op  in  4  requester 0 ALU control code
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, for requester 1
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 takes the result
rsp1_valid  out  1  result available for requester 1
rsp1_ready  in  1  requester 1 takes the result
rsp_data  out  WIDTH  registered result, shared by both response ports
rsp_flags  out  4  registered {zero, sign, carry, overflow}
rsp_err  out  1  registered flag: op code was >= NOPS
alu_a, alu_b  out  WIDTH  to ALU operand inputs
alu_ctrl  out  4  to ALU control input
alu_out  in  WIDTH  from ALU result
alu_flags  in  4  from ALU flags

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values: all ready/valid outputs 0; rsp_data, rsp_flags, rsp_err, alu_a, alu_b, alu_ctrl = 0; owner = 0; last_grant = 1, so requester 0 wins the first tie.
- IDLE:
  - reqN_ready is asserted combinationally only for the granted requester, and only in IDLE. Grant requires the corresponding reqN_valid.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - On grant: capture a, b and op into the operand registers; owner <= granted id; last_grant <= granted id; go to EXEC.
  - No request valid: stay in IDLE.
- EXEC (exactly one cycle):
  - Operand registers drive alu_a, alu_b and alu_ctrl.
  - rsp_data <= alu_out; rsp_flags <= alu_flags; rsp_err <= (op >= NOPS).
  - When the op is illegal, rsp_data and rsp_flags load 0 regardless of the ALU outputs.
  - Go to RESP.
- RESP:
  - rspN_valid = 1 only for N == owner; the other response valid stays 0.
  - Hold rsp_data, rsp_flags and rsp_err stable until rsp<owner>_ready is seen while valid.
  - On that handshake go to IDLE. A new grant is not taken in the same cycle.
  - A ready on the non-owner response port is ignored.
- Latency: handshake accepted in cycle T → rsp valid at T+2. Minimum issue interval is 3 cycles per operation.
- The ALU ports hold the last captured operands outside EXEC; they change only at a grant.
- Requester inputs are sampled only in the grant cycle. Changes to operands while the requester is waiting or not granted have no effect.
- A requester may drop valid before it is granted without side effects.
- Reset asserted in any state, including EXEC or RESP: the in-flight operation is discarded, no response is issued, and all registers return to their reset values on the next edge.
- No combinational path from rspN_ready to reqN_ready.

Test Plan:
- Single request: req0 ADD a=5 b=7 op=0 at cycle T → req0_ready=1 at T; rsp0_valid at T+2 with rsp_data=12, flags=4'b0000, rsp_err=0.
- Fair arbitration: req0 and req1 held valid continuously after reset → grants alternate 0,1,0,1. Each response returns to the matching port with the correct result.
- Flag passthrough:
  - SUB 0x80000000 − 1 → rsp_data=0x7FFFFFFF, flags=4'b0001.
  - ADD 0xFFFFFFFF + 1 → rsp_data=0, flags=4'b1010.
- Backpressure: hold rsp1_ready=0 for 5 cycles → rsp1_valid stays 1 and data stays stable; req0_ready stays 0 throughout; req0 is granted the cycle after the rsp1 handshake.
- Illegal op: op=4'b1100 → rsp_err=1, rsp_data=0, rsp_flags=0.
- Reset mid-operation: assert reset during EXEC → no rsp valid is ever issued for that op. After reset, with both requesters valid, requester 0 is granted first.
